// File: rtl/arb_pkg.sv
// arb_pkg: shared defaults and helpers for the arbiter grant FIFO
// Provides default parameter values, an index-width helper that never
// returns zero, and a one-hot test used by the grant decoder.
package arb_pkg;
    localparam int N_DEF      = 4;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    function automatic int clog2_min1(input int n);
        return n > 2 ? $clog2(n) : 1;
    endfunction

    function automatic logic onehot_chk(input logic [31:0] v);
        return v != '0 && (v & (v - 32'd1)) == '0;
    endfunction
endpackage

// File: rtl/onehot_to_bin.sv
// onehot_to_bin: decodes a grant vector into a binary index plus legality flags
// Ports:
//   onehot  in   N       grant vector
//   valid   out  1       exactly one bit set
//   multi   out  1       more than one bit set
//   idx     out  IW      binary index of the set bit (meaningful only when valid)
module onehot_to_bin
    import arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  onehot,
    output logic          valid,
    output logic          multi,
    output logic [IW-1:0] idx
);
    assign valid = onehot_chk(32'(onehot));
    assign multi = |onehot && !valid;

    // OR of set-bit positions; exact whenever the input is one-hot
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++)
            if (onehot[i]) idx = idx | IW'(i);
    end
endmodule

// File: rtl/arb_grant_fifo.sv
// arb_grant_fifo: captures arbiter-granted payloads into a first-word-fall-through FIFO
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   grant       one-hot grant from the arbiter
//   req_data    packed payloads, requester i at [i*DATA_W +: DATA_W]
//   ready       FIFO can accept this cycle (from registered count only)
//   ack         registered one-cycle pulse to the accepted requester
//   out_valid   head entry valid
//   out_ready   sink accepts the head
//   out_data    head payload
//   out_src     head source index
//   count       occupancy 0..DEPTH
//   err_multi   pulse: grant had more than one bit set
//   err_ovf     pulse: one-hot grant arrived while full
module arb_grant_fifo
    import arb_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N-1:0]                grant,
    input  logic [N*DATA_W-1:0]         req_data,
    output logic                        ready,
    output logic [N-1:0]                ack,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [clog2_min1(N)-1:0]    out_src,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        err_multi,
    output logic                        err_ovf
);
    localparam int IW = clog2_min1(N);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IW+DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 g_one, g_multi, push, pop;
    logic [IW-1:0]        g_idx;

    onehot_to_bin #(.N(N), .IW(IW)) u_dec (
        .onehot(grant),
        .valid (g_one),
        .multi (g_multi),
        .idx   (g_idx)
    );

    // ready ignores out_ready: a pop at full does not open a slot the same cycle
    assign ready     = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = g_one && ready;
    assign pop       = out_valid && out_ready;
    assign {out_src, out_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ack       <= '0;
            err_multi <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count     <= count + CW'(push) - CW'(pop);
            ack       <= push ? grant : '0;
            err_multi <= g_multi;
            err_ovf   <= g_one && !ready;
        end
    end

    // storage is not reset; pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {g_idx, req_data[g_idx*DATA_W +: DATA_W]};
    end
endmodule

// File: tb/tb_arb_grant_fifo.sv
// tb_arb_grant_fifo: directed vector table plus randomized run against a queue model
module tb_arb_grant_fifo;
    localparam int N = 4, DW = 8, D = 8;

    logic          clk = 1'b0;
    logic          rst, ready, out_valid, out_ready, err_multi, err_ovf;
    logic [N-1:0]  grant, ack;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic [3:0]    count;

    int total = 0, bad = 0;

    arb_grant_fifo #(.N(N), .DATA_W(DW), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .grant    (grant),
        .req_data (req_data),
        .ready    (ready),
        .ack      (ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_src  (out_src),
        .count    (count),
        .err_multi(err_multi),
        .err_ovf  (err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] g;
        logic       o;
        logic [3:0] cnt;
        logic [3:0] ack;
        logic       em;
        logic       eo;
        logic       ov;
        logic [1:0] src;
        logic [7:0] dat;
    } vec_t;

    vec_t tv[$];
    logic [9:0] q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] g, input logic o, input logic [3:0] cnt,
                       input logic [3:0] a, input logic em, input logic eo, input logic ov,
                       input logic [1:0] src, input logic [7:0] dat);
        tv.push_back('{r, g, o, cnt, a, em, eo, ov, src, dat});
    endtask

    task automatic drive(input logic r, input logic [3:0] g, input logic o, input logic [31:0] d);
        rst = r;
        grant = g;
        out_ready = o;
        req_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        grant = '0;
        out_ready = 1'b0;
        req_data = '0;
        // reset with all grant bits high
        add(1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        add(1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // single transfer, ack lasts one cycle
        add(0, 4'b0100, 0, 1, 4'b0100, 0, 0, 1, 2, 8'hCC);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 0, 1, 2, 8'hCC);
        // fill from empty with rotating grants
        add(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++)
            add(0, 4'(1 << (i % 4)), 0, 4'(i + 1), 4'(1 << (i % 4)), 0, 0, 1, 0, 8'hAA);
        // overflow at full
        add(0, 4'b0001, 0, 8, 0, 0, 1, 1, 0, 8'hAA);
        // drain in order
        for (int i = 0; i < 7; i++)
            add(0, 4'b0000, 1, 4'(7 - i), 0, 0, 0, 1, 2'((i + 1) % 4), 8'(8'hAA + 8'h11 * ((i + 1) % 4)));
        add(0, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 8'h00);
        // refill across pointer wrap
        add(0, 4'b1000, 0, 1, 4'b1000, 0, 0, 1, 3, 8'hDD);
        add(0, 4'b0010, 0, 2, 4'b0010, 0, 0, 1, 3, 8'hDD);
        add(0, 4'b0001, 0, 3, 4'b0001, 0, 0, 1, 3, 8'hDD);
        add(0, 4'b0000, 1, 2, 0, 0, 0, 1, 1, 8'hBB);
        add(0, 4'b0000, 1, 1, 0, 0, 0, 1, 0, 8'hAA);
        // push and pop together at count 1
        add(0, 4'b0100, 1, 1, 4'b0100, 0, 0, 1, 2, 8'hCC);
        for (int i = 0; i < 7; i++)
            add(0, 4'b0001, 0, 4'(i + 2), 4'b0001, 0, 0, 1, 2, 8'hCC);
        // at full a pop does not admit the grant
        add(0, 4'b0010, 1, 7, 0, 0, 1, 1, 0, 8'hAA);
        // illegal grant
        add(0, 4'b0101, 0, 7, 0, 1, 0, 1, 0, 8'hAA);
        add(0, 4'b0000, 1, 6, 0, 0, 0, 1, 0, 8'hAA);
        add(0, 4'b0000, 1, 5, 0, 0, 0, 1, 0, 8'hAA);
        // reset mid-stream
        add(1, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 8'h00);

        @(posedge clk);
        #1;
        foreach (tv[i]) begin
            drive(tv[i].r, tv[i].g, tv[i].o, 32'hDDCCBBAA);
            check($sformatf("v%0d count", i), 32'(count), 32'(tv[i].cnt));
            check($sformatf("v%0d ready", i), 32'(ready), 32'(tv[i].cnt != 4'd8));
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tv[i].ov));
            check($sformatf("v%0d ack", i), 32'(ack), 32'(tv[i].ack));
            check($sformatf("v%0d err_multi", i), 32'(err_multi), 32'(tv[i].em));
            check($sformatf("v%0d err_ovf", i), 32'(err_ovf), 32'(tv[i].eo));
            if (tv[i].ov) begin
                check($sformatf("v%0d out_src", i), 32'(out_src), 32'(tv[i].src));
                check($sformatf("v%0d out_data", i), 32'(out_data), 32'(tv[i].dat));
            end
        end

        // randomized run against a queue model
        drive(1, 4'b0000, 0, 32'h0);
        q.delete();
        for (int i = 0; i < 1500; i++) begin
            logic [3:0]  g;
            logic [31:0] d;
            logic        r, o, oh, rdy, pushm, popm;
            logic [3:0]  e_ack;
            logic        e_em, e_eo;
            int          k, s, ph;
            k = $urandom_range(0, 9);
            g = k < 2 ? 4'b0000 : k < 8 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(1, 15));
            ph = (i / 60) % 3;
            o = ph == 0 ? ($urandom_range(0, 9) < 2) : ph == 1 ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 149) == 0;
            d = $urandom;
            oh = $countones(g) == 1;
            rdy = q.size() != D;
            pushm = oh && rdy;
            popm = q.size() != 0 && o;
            e_ack = (!r && pushm) ? g : 4'b0000;
            e_em = !r && $countones(g) > 1;
            e_eo = !r && oh && !rdy;
            drive(r, g, o, d);
            if (r) q.delete();
            else begin
                if (popm) void'(q.pop_front());
                if (pushm) begin
                    s = $clog2(g);
                    q.push_back({2'(s), d[s*8 +: 8]});
                end
            end
            check("rnd count", 32'(count), 32'(q.size()));
            check("rnd ready", 32'(ready), 32'(q.size() != D));
            check("rnd out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("rnd ack", 32'(ack), 32'(e_ack));
            check("rnd err_multi", 32'(err_multi), 32'(e_em));
            check("rnd err_ovf", 32'(err_ovf), 32'(e_eo));
            if (q.size() != 0) check("rnd head", 32'({out_src, out_data}), 32'(q[0]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
